// File: rtl/branch_pkg.sv
// Shared types for the branch resolve path: branch kinds, condition codes
// and the NZCV bit positions used by the flag register.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_CBZ  = 3'd2,
    BR_CBNZ = 3'd3,
    BR_COND = 3'd4
  } br_type_t;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } shadow_state_t;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int SHADOW_W = 3;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: condition code plus stored NZCV -> taken.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n     = flags[FLAG_N];
    z     = flags[FLAG_Z];
    c     = flags[FLAG_C];
    v     = flags[FLAG_V];
    taken = 1'b1;
    case (cond)
      EQ:      taken = z;
      NE:      taken = ~z;
      HS:      taken = c;
      LO:      taken = ~c;
      MI:      taken = n;
      PL:      taken = ~n;
      VS:      taken = v;
      VC:      taken = ~v;
      HI:      taken = c & ~z;
      LS:      taken = ~(c & ~z);
      GE:      taken = (n == v);
      LT:      taken = (n != v);
      GT:      taken = ~z & (n == v);
      LE:      taken = ~(~z & (n == v));
      default: taken = 1'b1;  // AL and NV
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Holds NZCV, resolves B/CBZ/CBNZ/B.cond in EX and squashes younger slots
// after a taken branch. Optional taken/not-taken counters: BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [2:0]        ex_br_type,
  input  logic [3:0]        ex_cond,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_alu_flags,
  input  logic              ex_reg_zero,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [3:0]        flags,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
`ifdef BRANCH_STATS_EN
  output logic [31:0]       taken_count,
  output logic [31:0]       nt_count,
`endif
  output logic              squash
);

  localparam logic [SHADOW_W-1:0] FLUSH_INIT = SHADOW_W'(FLUSH_DEPTH);

  logic [3:0]          flags_q, flags_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                redirect_q, redirect_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;

  shadow_state_t shadow_state;
  logic          accept;
  logic          is_cond_br;
  logic          cond_true;
  logic          taken;

  cond_eval u_cond_eval (
    .cond  (ex_cond),
    .flags (flags_q),
    .taken (cond_true)
  );

  // An instruction in EX is dead while the shadow is active.
  always_comb begin
    shadow_state = (shadow_q != '0) ? ST_SHADOW : ST_IDLE;
    accept       = ex_valid & ~stall & (shadow_state == ST_IDLE);
    is_cond_br   = 1'b0;
    taken        = 1'b0;
    case (ex_br_type)
      BR_B:    taken = 1'b1;
      BR_CBZ:  begin is_cond_br = 1'b1; taken = ex_reg_zero;  end
      BR_CBNZ: begin is_cond_br = 1'b1; taken = ~ex_reg_zero; end
      BR_COND: begin is_cond_br = 1'b1; taken = cond_true;    end
      default: taken = 1'b0;
    endcase
    taken = taken & accept;
  end

  // Redirect is a single pulse and is not held by stall.
  always_comb begin
    flags_d    = flags_q;
    shadow_d   = shadow_q;
    redirect_d = 1'b0;
    pc_d       = pc_q;
    if (accept && ex_set_flags) flags_d = ex_alu_flags;
    if (taken) begin
      shadow_d   = FLUSH_INIT;
      pc_d       = ex_target;
      redirect_d = 1'b1;
    end else if (shadow_state == ST_SHADOW && !stall) begin
      shadow_d = shadow_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q    <= '0;
      shadow_q   <= '0;
      redirect_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      flags_q    <= flags_d;
      shadow_q   <= shadow_d;
      redirect_q <= redirect_d;
      pc_q       <= pc_d;
    end
  end

  assign flags       = flags_q;
  assign redirect    = redirect_q;
  assign redirect_pc = pc_q;
  assign squash      = (shadow_state == ST_SHADOW);

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] nt_cnt_q, nt_cnt_d;

  // Unconditional B is counted as taken; counters wrap naturally.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    nt_cnt_d    = nt_cnt_q;
    if (taken) taken_cnt_d = taken_cnt_q + 32'd1;
    else if (accept && is_cond_br) nt_cnt_d = nt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      nt_cnt_q    <= nt_cnt_d;
    end
  end

  assign taken_count = taken_cnt_q;
  assign nt_count    = nt_cnt_q;
`else
  logic unused_cond_br;
  assign unused_cond_br = is_cond_br;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumer end of the ALU zero/flag path in the 5-stage pipeline. It holds the architectural NZCV flag register written by flag-setting instructions in EX, and resolves B, CBZ, CBNZ and B.cond. CBZ/CBNZ use the 64-bit operand zero flag. B.cond uses the stored flags. On a taken branch it issues a registered redirect to IF and squashes younger instructions for a fixed number of unstalled cycles.

## Interface
- FLUSH_DEPTH, 2, younger pipeline slots (IF, ID) squashed after a redirect; legal range 1–7.
- ADDR_W, 64, branch target / PC width.

- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- stall  in  1  pipeline stall; freezes all state, no instruction accepted.
- ex_valid  in  1  instruction present in EX.
- ex_br_type  in  3  BR_NONE=0, BR_B=1, BR_CBZ=2, BR_CBNZ=3, BR_COND=4; codes 5–7 behave as BR_NONE.
- ex_cond  in  4  B.cond condition code; used only for BR_COND.
- ex_set_flags  in  1  instruction writes NZCV.
- ex_alu_flags  in  4  {N,Z,C,V} produced by this instruction's ALU op.
- ex_reg_zero  in  1  1 when the CBZ/CBNZ operand is all-zero.
- ex_target  in  ADDR_W  branch target address.
- flags  out  4  registered NZCV; reset 4'b0000.
- redirect  out  1  one-cycle pulse, fetch from redirect_pc; reset 0.
- redirect_pc  out  ADDR_W  target latched on a taken branch; reset 0, holds between redirects.
- squash  out  1  kill instructions in IF/ID while high; reset 0.

## Operation
- Accept condition: ex_valid & !stall & (shadow == 0). Accept is never asserted while squash is high, so in-shadow EX instructions are dead: no flag write and no branch.
- Flag write: on accept with ex_set_flags=1, flags <= ex_alu_flags. A B.cond in the next accepted instruction sees the new value. No same-cycle forwarding.
- Taken decision on accept:
  - BR_B: always taken.
  - BR_CBZ: taken when ex_reg_zero=1.
  - BR_CBNZ: taken when ex_reg_zero=0.
  - BR_COND: taken when cond_eval(ex_cond, flags) is true.
- cond_eval:
  - EQ=0 Z; NE=1 !Z.
  - HS=2 C; LO=3 !C.
  - MI=4 N; PL=5 !N.
  - VS=6 V; VC=7 !V.
  - HI=8 C&!Z; LS=9 !(C&!Z).
  - GE=A N==V; LT=B N!=V.
  - GT=C !Z&(N==V); LE=D !(that).
  - AL=E and NV=F: always true.
- One instruction both setting flags and being a B.cond is illegal. Condition then uses the old flags; not checked.
- Shadow counter (3 bits), states IDLE (0) / SHADOW (>0):
  - Taken accept: shadow <= FLUSH_DEPTH, redirect_pc <= ex_target, redirect <= 1.
  - While shadow > 0 and !stall: decrement.
  - While stall: hold.
- squash = (shadow != 0), combinational from the counter.

## Timing
- Accept at edge k:
  - flags valid after edge k.
  - redirect high for exactly the cycle after edge k, even if stall rises in that cycle.
  - squash high from after edge k for FLUSH_DEPTH unstalled cycles.
- Stall during SHADOW stretches squash by the stalled cycles. Redirect is not repeated.
- Not-taken branch: no redirect, no squash, zero penalty.
- Back-to-back branches: the second is in the shadow and is ignored. Earliest next accept is edge k+FLUSH_DEPTH+1 with no stall.
- Reset asserted mid-shadow: flags, shadow, redirect and redirect_pc clear asynchronously. After deassertion the first accept is on the next edge.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs taken_count and nt_count (32 bits each, reset 0).
  - On accepted conditional branches (CBZ/CBNZ/COND), the matching counter increments; it wraps from 32'hFFFFFFFF to 0.
  - BR_B counts as taken.
- BRANCH_STATS_EN undefined: ports and counters absent. Behaviour otherwise identical.

## Structure
- Shared package branch_pkg holds:
  - br_type_t enum.
  - cond_t enum (EQ..NV).
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0).
- Sub-module cond_eval: combinational (ex_cond, flags) -> taken. Instantiated once.

## Test plan
- Reset low with all inputs random -> flags=0, redirect=0, squash=0, redirect_pc=0. Release reset, then idle -> outputs unchanged.
- Accept SUBS with ex_alu_flags=4'b0100. Next cycle accept BR_COND, ex_cond=EQ, ex_target=64'h400 -> redirect pulse one cycle, redirect_pc=64'h400, squash high exactly 2 cycles.
- BR_CBZ with ex_reg_zero=0 -> no redirect, no squash. Then BR_CBNZ with ex_reg_zero=0, target 64'h80 -> redirect, redirect_pc=64'h80.
- Flags 4'b1001 (N=1, V=1), BR_COND GT -> taken. Flags 4'b1000 with GE -> not taken. LT -> taken.
- Taken BR_B, then stall high 3 cycles after the redirect cycle -> squash high 5 cycles total. BR_B presented at ex_valid during the shadow -> ignored.
- Taken branch, reset pulled low in the first squash cycle -> squash, redirect and flags drop immediately. With BRANCH_STATS_EN: 3 taken and 2 not-taken CBZ -> taken_count=3, nt_count=2.
